vote_tally_engine: RTL and testbench

Parametrised N-party voting core: the next-generation replacement for the fixed three-button voting machine. It debounces one button per party and accepts exactly one vote per officer-armed ballot. Tallies are kept in saturating counters, and per-party counts plus an optional winner/tie result are presented in display mode. It sits between the raw front-panel buttons and the LED/result display.

---
 rtl/vote_pkg.sv | 40 ++++
 rtl/vote_debounce.sv | 38 +++
 rtl/vote_tally_engine.sv | 188 ++++++++++++++++++
 tb/tb_vote_tally_engine.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/vote_pkg.sv
// Shared types and helpers for the vote tally engine: FSM state encoding,
// press population count and lowest-set-index priority pick.
package vote_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        HOLD    = 2'd2,
        DISPLAY = 2'd3
    } vote_state_e;

    localparam int MAX_PARTIES = 16;

    function automatic int unsigned onehot_count(input logic [MAX_PARTIES-1:0] vec);
        int unsigned n;
        n = 32'd0;
        for (int i = 0; i < MAX_PARTIES; i++) begin
            if (vec[i]) begin
                n = n + 32'd1;
            end else begin
                n = n;
            end
        end
        return n;
    endfunction

    function automatic logic [3:0] lowest_set_index(input logic [MAX_PARTIES-1:0] vec);
        logic [3:0] idx;
        idx = 4'd0;
        for (int i = MAX_PARTIES - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = 4'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/vote_debounce.sv
// Per-button debouncer: one registered press pulse after DEBOUNCE_CYC
// consecutive high samples, then frozen until the button is released.
module vote_debounce #(
    parameter int DEBOUNCE_CYC = 10
) (
    input  logic clock,
    input  logic reset,
    input  logic button,
    output logic press
);
    localparam int CW = $clog2(DEBOUNCE_CYC + 1);

    logic [CW-1:0] cnt_r;
    logic          press_r;

    // Consecutive-high counter and single-shot press pulse
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_r   <= CW'(0);
            press_r <= 1'b0;
        end else if (!button) begin
            cnt_r   <= CW'(0);
            press_r <= 1'b0;
        end else if (cnt_r == CW'(DEBOUNCE_CYC - 1)) begin
            cnt_r   <= CW'(DEBOUNCE_CYC);
            press_r <= 1'b1;
        end else if (cnt_r == CW'(DEBOUNCE_CYC)) begin
            cnt_r   <= cnt_r;
            press_r <= 1'b0;
        end else begin
            cnt_r   <= cnt_r + CW'(1);
            press_r <= 1'b0;
        end
    end

    assign press = press_r;

endmodule

// File: rtl/vote_tally_engine.sv
// N-party ballot core: debounced presses, one vote per armed ballot,
// saturating tallies and display mode. Define VOTE_WINNER_EN for winner/tie logic.
module vote_tally_engine
    import vote_pkg::*;
#(
    parameter int NUM_PARTIES  = 4,
    parameter int CNT_W        = 8,
    parameter int DEBOUNCE_CYC = 10,
    parameter int LED_HOLD_CYC = 10
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           mode,
    input  logic                           ballot_en,
    input  logic [NUM_PARTIES-1:0]         button,
    output logic [CNT_W-1:0]               led,
    output logic                           ballot_ready,
    output logic                           vote_ack,
    output logic                           multi_err,
    output logic [NUM_PARTIES-1:0]         sat,
    output logic [$clog2(NUM_PARTIES)-1:0] winner_idx,
    output logic                           winner_valid,
    output logic                           tie
);
    localparam int IDX_W  = $clog2(NUM_PARTIES);
    localparam int HOLD_W = $clog2(LED_HOLD_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [NUM_PARTIES-1:0] press_s;
    logic [MAX_PARTIES-1:0] press_pad_s;
    int unsigned            press_num_s;
    logic [IDX_W-1:0]       press_idx_s;

    vote_state_e            state_r, state_nxt_s;
    logic                   accept_s, reject_s;
    logic [HOLD_W-1:0]      hold_cnt_r;
    logic [CNT_W-1:0]       count_r [NUM_PARTIES];
    logic [IDX_W-1:0]       sel_r;
    logic [CNT_W-1:0]       led_r;
    logic                   ballot_ready_r, vote_ack_r, multi_err_r;
    logic [NUM_PARTIES-1:0] sat_r;

    for (genvar g = 0; g < NUM_PARTIES; g++) begin : g_deb
        vote_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_deb (
            .clock  (clock),
            .reset  (reset),
            .button (button[g]),
            .press  (press_s[g])
        );
    end

    assign press_pad_s = MAX_PARTIES'(press_s);
    assign press_num_s = onehot_count(press_pad_s);
    assign press_idx_s = IDX_W'(lowest_set_index(press_pad_s));

    // Next-state decode; display mode overrides every other state
    always_comb begin
        state_nxt_s = state_r;
        accept_s    = 1'b0;
        reject_s    = 1'b0;
        if (mode) begin
            state_nxt_s = DISPLAY;
        end else begin
            case (state_r)
                IDLE: begin
                    if (ballot_en) state_nxt_s = ARMED;
                    else           state_nxt_s = IDLE;
                end
                ARMED: begin
                    if (press_num_s == 32'd1) begin
                        accept_s    = 1'b1;
                        state_nxt_s = HOLD;
                    end else if (press_num_s > 32'd1) begin
                        reject_s    = 1'b1;
                        state_nxt_s = ARMED;
                    end else begin
                        state_nxt_s = ARMED;
                    end
                end
                HOLD: begin
                    if (hold_cnt_r == HOLD_W'(LED_HOLD_CYC - 1)) state_nxt_s = IDLE;
                    else                                         state_nxt_s = HOLD;
                end
                DISPLAY: state_nxt_s = IDLE;
                default: state_nxt_s = IDLE;
            endcase
        end
    end

    // State register and LED hold timer
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r    <= IDLE;
            hold_cnt_r <= HOLD_W'(0);
        end else begin
            state_r <= state_nxt_s;
            if (state_r == HOLD && state_nxt_s == HOLD) hold_cnt_r <= hold_cnt_r + HOLD_W'(1);
            else                                        hold_cnt_r <= HOLD_W'(0);
        end
    end

    // Saturating tallies; a vote at max only raises the sticky flag
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NUM_PARTIES; i++) count_r[i] <= CNT_W'(0);
            sat_r <= '0;
        end else if (accept_s) begin
            for (int i = 0; i < NUM_PARTIES; i++) begin
                if (press_s[i] && count_r[i] == CNT_MAX) sat_r[i]   <= 1'b1;
                else if (press_s[i])                     count_r[i] <= count_r[i] + CNT_W'(1);
            end
        end
    end

    // Display select and registered front-panel outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            sel_r          <= IDX_W'(0);
            led_r          <= CNT_W'(0);
            ballot_ready_r <= 1'b0;
            vote_ack_r     <= 1'b0;
            multi_err_r    <= 1'b0;
        end else begin
            if (state_r == DISPLAY && |press_s) sel_r <= press_idx_s;
            case (state_r)
                HOLD:    led_r <= CNT_MAX;
                DISPLAY: led_r <= count_r[sel_r];
                default: led_r <= CNT_W'(0);
            endcase
            ballot_ready_r <= (state_nxt_s == ARMED);
            vote_ack_r     <= accept_s;
            multi_err_r    <= reject_s;
        end
    end

`ifdef VOTE_WINNER_EN
    logic [CNT_W-1:0] max_s;
    logic [IDX_W-1:0] win_idx_s, winner_idx_r;
    logic             tie_s, tie_r, winner_valid_r;

    // Maximum search, lowest index kept on equal counts
    always_comb begin
        max_s     = count_r[0];
        win_idx_s = IDX_W'(0);
        tie_s     = 1'b0;
        for (int i = 1; i < NUM_PARTIES; i++) begin
            if (count_r[i] > max_s) begin
                max_s     = count_r[i];
                win_idx_s = IDX_W'(i);
            end else begin
                max_s = max_s;
            end
        end
        for (int i = 0; i < NUM_PARTIES; i++) begin
            if (IDX_W'(i) != win_idx_s && count_r[i] == max_s) tie_s = 1'b1;
            else                                               tie_s = tie_s;
        end
    end

    // Registered winner outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            winner_idx_r   <= IDX_W'(0);
            tie_r          <= 1'b0;
            winner_valid_r <= 1'b0;
        end else begin
            winner_idx_r   <= win_idx_s;
            tie_r          <= tie_s;
            winner_valid_r <= (state_r == DISPLAY) && (max_s != CNT_W'(0));
        end
    end

    assign winner_idx   = winner_idx_r;
    assign tie          = tie_r;
    assign winner_valid = winner_valid_r;
`else
    assign winner_idx   = IDX_W'(0);
    assign tie          = 1'b0;
    assign winner_valid = 1'b0;
`endif

    assign led          = led_r;
    assign ballot_ready = ballot_ready_r;
    assign vote_ack     = vote_ack_r;
    assign multi_err    = multi_err_r;
    assign sat          = sat_r;

endmodule

// File: tb/tb_vote_tally_engine.sv
// Scoreboard bench for vote_tally_engine: expected ack/multi_err events are queued
// by stimulus and popped by a monitor; tallies are read back through display mode.
module tb_vote_tally_engine;
    localparam int NP = 4;
    localparam int CW = 8;
    localparam int EV_ACK  = 1;
    localparam int EV_MERR = 2;

    logic          clock = 1'b0;
    logic          reset, mode, ballot_en;
    logic [NP-1:0] button;
    logic [CW-1:0] led;
    logic          ballot_ready, vote_ack, multi_err, winner_valid, tie;
    logic [NP-1:0] sat;
    logic [1:0]    winner_idx;

    int checks = 0;
    int errors = 0;
    int exp_q[$];

    always #5 clock = ~clock;

    vote_tally_engine #(.NUM_PARTIES(NP), .CNT_W(CW), .DEBOUNCE_CYC(10), .LED_HOLD_CYC(10)) dut (
        .clock(clock), .reset(reset), .mode(mode), .ballot_en(ballot_en), .button(button),
        .led(led), .ballot_ready(ballot_ready), .vote_ack(vote_ack), .multi_err(multi_err),
        .sat(sat), .winner_idx(winner_idx), .winner_valid(winner_valid), .tie(tie)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic pop_event(input int kind);
        if (exp_q.size() == 0) chk("unexpected_event", kind, 0);
        else                   chk("event_kind", kind, exp_q.pop_front());
    endtask

    // Monitor: every ack/multi_err pulse must match the next queued expectation
    always @(negedge clock) begin
        if (vote_ack)  pop_event(EV_ACK);
        if (multi_err) pop_event(EV_MERR);
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic cast(input int p);
        exp_q.push_back(EV_ACK);
        ballot_en = 1'b1; tick(); ballot_en = 1'b0;
        button[p] = 1'b1; repeat (12) tick();
        button[p] = 1'b0; repeat (12) tick();
    endtask

    task automatic press(input logic [NP-1:0] mask, input int n);
        button = mask; repeat (n) tick();
        button = '0;   repeat (12) tick();
    endtask

    task automatic show(input int p, input int exp, input string name);
        mode = 1'b1; tick(); tick();
        button[p] = 1'b1; repeat (12) tick();
        button[p] = 1'b0; tick(); tick();
        chk(name, led, exp);
    endtask

    task automatic read_count(input int p, input int exp, input string name);
        show(p, exp, name);
        mode = 1'b0; tick(); tick();
    endtask

    initial begin
        int ack_k, led_k, led_n;
        reset = 1'b1; mode = 1'b0; ballot_en = 1'b0; button = '0;
        repeat (3) tick();
        chk("rst_led", led, 0);
        chk("rst_ready", ballot_ready, 0);
        chk("rst_sat", sat, 0);
        chk("rst_widx", winner_idx, 0);
        chk("rst_wvalid", winner_valid, 0);
        chk("rst_tie", tie, 0);
        reset = 1'b0; tick();

        // One vote for party 2: ack latency and exact LED hold length
        ballot_en = 1'b1; tick(); ballot_en = 1'b0;
        chk("armed_ready", ballot_ready, 1);
        exp_q.push_back(EV_ACK);
        button[2] = 1'b1;
        ack_k = -1; led_k = -1; led_n = 0;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (vote_ack && ack_k < 0) ack_k = k;
            if (led == 8'hFF) begin
                led_n++;
                if (led_k < 0) led_k = k;
            end
            if (k == 11) button[2] = 1'b0;
        end
        chk("ack_latency", ack_k, 10);
        chk("led_first", led_k, 11);
        chk("led_hold_len", led_n, 10);
        chk("idle_ready", ballot_ready, 0);
        chk("idle_led", led, 0);

        // Press without a ballot is ignored
        press(4'b0010, 12);

        // Too-short press, then simultaneous presses, then a clean vote for party 3
        ballot_en = 1'b1; tick(); ballot_en = 1'b0;
        press(4'b1000, 9);
        chk("short_press_ready", ballot_ready, 1);
        exp_q.push_back(EV_MERR);
        press(4'b1001, 12);
        chk("multi_ready", ballot_ready, 1);
        exp_q.push_back(EV_ACK);
        press(4'b1000, 12);
        chk("vote3_ready", ballot_ready, 0);

        read_count(0, 0, "cnt0_a");
        read_count(1, 0, "cnt1_a");
        read_count(2, 1, "cnt2_a");
        read_count(3, 1, "cnt3_a");

        // Reset during HOLD clears LED and tallies on the next edge
        exp_q.push_back(EV_ACK);
        ballot_en = 1'b1; tick(); ballot_en = 1'b0;
        button[0] = 1'b1; repeat (14) tick();
        chk("hold_led", led, 255);
        reset = 1'b1; button = '0; tick();
        chk("rst_hold_led", led, 0);
        chk("rst_hold_ready", ballot_ready, 0);
        reset = 1'b0; tick();
        read_count(0, 0, "cnt0_rst");
        read_count(2, 0, "cnt2_rst");
        read_count(3, 0, "cnt3_rst");

        // Votes 3/5/5/0 and winner readout
        for (int i = 0; i < 3; i++) cast(0);
        for (int i = 0; i < 5; i++) cast(1);
        for (int i = 0; i < 5; i++) cast(2);
        show(3, 0, "disp_cnt3");
        show(2, 5, "disp_cnt2");
`ifdef VOTE_WINNER_EN
        chk("winner_idx", winner_idx, 1);
        chk("winner_tie", tie, 1);
        chk("winner_valid", winner_valid, 1);
`else
        chk("winner_idx", winner_idx, 0);
        chk("winner_tie", tie, 0);
        chk("winner_valid", winner_valid, 0);
`endif
        mode = 1'b0; tick(); tick();
        chk("disp_exit_led", led, 0);
        chk("disp_exit_valid", winner_valid, 0);
        read_count(0, 3, "cnt0_b");

        // Display mode discards an armed ballot
        ballot_en = 1'b1; tick(); ballot_en = 1'b0;
        chk("rearm_ready", ballot_ready, 1);
        mode = 1'b1; tick(); tick();
        chk("discard_ready", ballot_ready, 0);
        mode = 1'b0; tick(); tick();
        chk("discard_idle_ready", ballot_ready, 0);
        read_count(0, 3, "cnt0_c");
        read_count(1, 5, "cnt1_c");

        // Saturation at 255 for party 1
        reset = 1'b1; tick(); tick(); reset = 1'b0; tick();
        for (int i = 0; i < 255; i++) cast(1);
        chk("sat_before", sat, 0);
        read_count(1, 255, "cnt1_255");
        cast(1);
        chk("sat_after", sat, 2);
        read_count(1, 255, "cnt1_sat");

        repeat (3) tick();
        chk("queue_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
